// File: rtl/uart_cmd_pkg.sv
// Purpose : opcodes and FSM state encodings shared by the UART debug command bridge.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// State encodings are fixed 4-bit values because they are shown on the 7-segment display.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_HALT   = 8'h00;
   localparam logic [7:0] CMD_RESUME = 8'h01;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_READ   = 8'h03;

   // Value returned for a read attempted while the CPU still owns the bus.
   localparam logic [7:0] RD_REFUSED = 8'hFF;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_ADDR_HI  = 4'd1;
   localparam logic [3:0] ST_ADDR_LO  = 4'd2;
   localparam logic [3:0] ST_WDATA    = 4'd3;
   localparam logic [3:0] ST_WR_BUS   = 4'd4;
   localparam logic [3:0] ST_RD_BUS   = 4'd5;
   localparam logic [3:0] ST_RD_WAIT  = 4'd6;
   localparam logic [3:0] ST_TX_START = 4'd7;
   localparam logic [3:0] ST_TX_WAIT  = 4'd8;

   typedef enum logic [3:0] {
      IDLE     = ST_IDLE,
      ADDR_HI  = ST_ADDR_HI,
      ADDR_LO  = ST_ADDR_LO,
      WDATA    = ST_WDATA,
      WR_BUS   = ST_WR_BUS,
      RD_BUS   = ST_RD_BUS,
      RD_WAIT  = ST_RD_WAIT,
      TX_START = ST_TX_START,
      TX_WAIT  = ST_TX_WAIT
   } state_t;

endpackage

// File: rtl/uart_cmd_bridge.sv
// Purpose : device side of the UART debug protocol; parses rx bytes into halt/resume/bus write/bus read.
// Latency : read response tx_start lands RD_LATENCY+3 cycles after the addr_lo byte (tx idle case).
// Backpressure: none on rx (bytes arriving mid-execution are dropped); tx_start waits for tx_active=0.
//
// Ports: clk/rst (async, active-low); rx_valid/rx_data from UART_RX; tx_start/tx_data/tx_active/tx_done
//        to UART_TX; cpu_halt to the CPU halt logic; bus_addr/bus_wdata/bus_we/bus_re/bus_rdata to the
//        memory bus; state_dbg shows the FSM encoding.
// Build option: define UART_CMD_TIMEOUT_EN to abort partial commands after TIMEOUT_CYCLES of rx silence.
module uart_cmd_bridge
   import uart_cmd_pkg::*;
#(
   parameter int RD_LATENCY     = 1,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_active,
   input  logic        tx_done,
   output logic        cpu_halt,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [7:0]  bus_rdata,
   output logic [3:0]  state_dbg
);

   if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
      $error("uart_cmd_bridge: RD_LATENCY must be 1..7");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_cmd_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   localparam logic [2:0] RD_LAT = RD_LATENCY[2:0];

   state_t      state;
   logic [15:0] addr_q;     // assembled address; bus_addr only follows it on a real access
   logic [7:0]  wdata_q;
   logic        is_write;
   logic [2:0]  lat_cnt;
   logic        tmo_abort;

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic             partial_cmd;
   logic [TMO_W-1:0] tmo_cnt;

   assign partial_cmd = (state == ADDR_HI) || (state == ADDR_LO) || (state == WDATA);
   // A byte arriving on the very last cycle still wins over the abort.
   assign tmo_abort   = partial_cmd && !rx_valid && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (rx_valid || !partial_cmd) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_write  <= 1'b0;
         lat_cnt   <= '0;
         cpu_halt  <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         bus_re    <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
      end else begin
         bus_we   <= 1'b0;
         bus_re   <= 1'b0;
         tx_start <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_HALT:   cpu_halt <= 1'b1;
                     CMD_RESUME: cpu_halt <= 1'b0;
                     CMD_WRITE: begin
                        is_write <= 1'b1;
                        state    <= ADDR_HI;
                     end
                     CMD_READ: begin
                        is_write <= 1'b0;
                        state    <= ADDR_HI;
                     end
                     default: ;
                  endcase
               end
            end

            ADDR_HI: begin
               if (rx_valid) begin
                  addr_q[15:8] <= rx_data;
                  state        <= ADDR_LO;
               end
            end

            ADDR_LO: begin
               if (rx_valid) begin
                  addr_q[7:0] <= rx_data;
                  state       <= is_write ? WDATA : RD_BUS;
               end
            end

            WDATA: begin
               if (rx_valid) begin
                  wdata_q <= rx_data;
                  state   <= WR_BUS;
               end
            end

            WR_BUS: begin
               // The bus belongs to the CPU unless halted, so an unhalted write is silently dropped.
               if (cpu_halt) begin
                  bus_we    <= 1'b1;
                  bus_addr  <= addr_q;
                  bus_wdata <= wdata_q;
               end
               state <= IDLE;
            end

            RD_BUS: begin
               if (cpu_halt) begin
                  bus_re   <= 1'b1;
                  bus_addr <= addr_q;
                  lat_cnt  <= RD_LAT;
                  state    <= RD_WAIT;
               end else begin
                  tx_data <= RD_REFUSED;
                  state   <= TX_START;
               end
            end

            RD_WAIT: begin
               if (lat_cnt == 3'd0) begin
                  tx_data <= bus_rdata;
                  // Launch straight from here when the transmitter is free to save the TX_START cycle.
                  if (!tx_active) begin
                     tx_start <= 1'b1;
                     state    <= TX_WAIT;
                  end else begin
                     state <= TX_START;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            TX_START: begin
               if (!tx_active) begin
                  tx_start <= 1'b1;
                  state    <= TX_WAIT;
               end
            end

            TX_WAIT: begin
               if (tx_done) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase

         if (tmo_abort) begin
            state <= IDLE;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Purpose : self-checking bench for uart_cmd_bridge (command vectors plus multi-cycle corner cases).
// Latency : n/a.
// Backpressure: a UART_TX model holds tx_active for a fixed time after each tx_start.
module tb_uart_cmd_bridge;

   localparam int LAT     = 2;
   localparam int TMO     = 40;
   localparam int TX_BUSY = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_active;
   logic        tx_done;
   logic        cpu_halt;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [7:0]  bus_rdata;
   logic [3:0]  state_dbg;

   logic        model_active;
   logic        ext_busy;
   logic [LAT:0] re_hist;
   logic [7:0]  rd_val;
   int          tx_left;
   int          we_cnt, re_cnt, tx_cnt;
   logic [7:0]  tx_seen;

   int n_chk = 0;
   int n_err = 0;

   always #20 clk = ~clk;

   assign tx_active = model_active | ext_busy;
   // Read data is only meaningful exactly LAT cycles after bus_re; anything else returns junk.
   assign bus_rdata = re_hist[LAT] ? rd_val : 8'hEE;

   uart_cmd_bridge #(.RD_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_active (tx_active),
      .tx_done   (tx_done),
      .cpu_halt  (cpu_halt),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_rdata (bus_rdata),
      .state_dbg (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus and UART_TX models, all updated mid-cycle on the falling edge.
   initial begin
      model_active = 1'b0;
      tx_done      = 1'b0;
      tx_left      = 0;
      re_hist      = '0;
      we_cnt       = 0;
      re_cnt       = 0;
      tx_cnt       = 0;
      tx_seen      = 8'h00;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (bus_we) we_cnt++;
         if (bus_re) re_cnt++;
         re_hist = {re_hist[LAT-1:0], bus_re};
         if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) begin
               model_active = 1'b0;
               tx_done      = 1'b1;
               chk("tx_data_held", {24'd0, tx_data}, {24'd0, tx_seen});
            end
         end else if (tx_start) begin
            tx_cnt++;
            tx_seen      = tx_data;
            model_active = 1'b1;
            tx_left      = TX_BUSY;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] bytes;   // first byte in [31:24]
      int          n;
      logic [7:0]  rdv;
      logic        halt;
      int          we;
      int          re;
      int          tx;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [7:0]  txd;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0, re0, tx0, k;

      //          bytes         n  rdv    halt we re tx addr      wd     txd
      vecs[0]  = '{32'h00000000, 1, 8'h00, 1'b1, 0, 0, 0, 16'h0000, 8'h00, 8'h00};
      vecs[1]  = '{32'h01000000, 1, 8'h00, 1'b0, 0, 0, 0, 16'h0000, 8'h00, 8'h00};
      vecs[2]  = '{32'h07000000, 1, 8'h00, 1'b0, 0, 0, 0, 16'h0000, 8'h00, 8'h00};
      vecs[3]  = '{32'h00000000, 1, 8'h00, 1'b1, 0, 0, 0, 16'h0000, 8'h00, 8'h00};
      vecs[4]  = '{32'h02200088, 4, 8'h00, 1'b1, 1, 0, 0, 16'h2000, 8'h88, 8'h00};
      vecs[5]  = '{32'h033F0000, 3, 8'h0F, 1'b1, 0, 1, 1, 16'h3F00, 8'h88, 8'h0F};
      vecs[6]  = '{32'hFF000000, 1, 8'h00, 1'b1, 0, 0, 0, 16'h3F00, 8'h88, 8'h00};
      vecs[7]  = '{32'h01000000, 1, 8'h00, 1'b0, 0, 0, 0, 16'h3F00, 8'h88, 8'h00};
      vecs[8]  = '{32'h02200755, 4, 8'h00, 1'b0, 0, 0, 0, 16'h3F00, 8'h88, 8'h00};
      vecs[9]  = '{32'h03200700, 3, 8'h33, 1'b0, 0, 0, 1, 16'h3F00, 8'h88, 8'hFF};
      vecs[10] = '{32'h00000000, 1, 8'h00, 1'b1, 0, 0, 0, 16'h3F00, 8'h88, 8'h00};
      vecs[11] = '{32'h03000100, 3, 8'h5A, 1'b1, 0, 1, 1, 16'h0001, 8'h88, 8'h5A};
      vecs[12] = '{32'h020001A5, 4, 8'h00, 1'b1, 1, 0, 0, 16'h0001, 8'hA5, 8'h00};

      // Reset
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      ext_busy = 1'b0;
      rd_val   = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_halt",  {31'd0, cpu_halt}, 32'd0);
      chk("rst_state", {28'd0, state_dbg}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_halt",    {31'd0, cpu_halt}, 32'd0);
      chk("post_rst_we",      {31'd0, bus_we},   32'd0);
      chk("post_rst_re",      {31'd0, bus_re},   32'd0);
      chk("post_rst_txstart", {31'd0, tx_start}, 32'd0);
      chk("post_rst_state",   {28'd0, state_dbg}, 32'd0);
      chk("post_rst_txdata",  {24'd0, tx_data},  32'd0);
      chk("post_rst_addr",    {16'd0, bus_addr}, 32'd0);

      // Table-driven command vectors
      for (int i = 0; i < 13; i++) begin
         logic [31:0] bs;
         bs     = vecs[i].bytes;
         rd_val = vecs[i].rdv;
         we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
         for (int j = 0; j < vecs[i].n; j++) begin
            send_byte(bs[31:24]);
            bs = bs << 8;
         end
         repeat (20) @(negedge clk);
         chk($sformatf("v%0d_halt", i),  {31'd0, cpu_halt}, {31'd0, vecs[i].halt});
         chk($sformatf("v%0d_we", i),    we_cnt - we0, vecs[i].we);
         chk($sformatf("v%0d_re", i),    re_cnt - re0, vecs[i].re);
         chk($sformatf("v%0d_tx", i),    tx_cnt - tx0, vecs[i].tx);
         chk($sformatf("v%0d_addr", i),  {16'd0, bus_addr}, {16'd0, vecs[i].addr});
         chk($sformatf("v%0d_wdata", i), {24'd0, bus_wdata}, {24'd0, vecs[i].wd});
         chk($sformatf("v%0d_state", i), {28'd0, state_dbg}, 32'd0);
         if (vecs[i].tx != 0)
            chk($sformatf("v%0d_txdata", i), {24'd0, tx_seen}, {24'd0, vecs[i].txd});
      end

      // Read latency: halted, tx idle, count cycles from the addr_lo byte to tx_start
      rd_val = 8'hC3;
      re0 = re_cnt;
      send_byte(8'h03);
      send_byte(8'h12);
      rx_data  = 8'h34;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      k = 1;
      while (!tx_start && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("rd_latency_ok", {31'd0, (k <= LAT + 3)}, 32'd1);
      repeat (20) @(negedge clk);
      chk("lat_txdata", {24'd0, tx_seen}, 32'h0C3);
      chk("lat_re",     re_cnt - re0, 1);
      chk("lat_addr",   {16'd0, bus_addr}, 32'h1234);

      // Bytes arriving during TX_WAIT are discarded
      send_byte(8'h01);
      tx0 = tx_cnt;
      send_byte(8'h03);
      send_byte(8'hAB);
      send_byte(8'hCD);
      k = 0;
      while (!tx_start && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("discard_saw_txstart", {31'd0, tx_start}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (20) @(negedge clk);
      chk("discard_halt",  {31'd0, cpu_halt}, 32'd0);
      chk("discard_tx",    tx_cnt - tx0, 1);
      chk("discard_txd",   {24'd0, tx_seen}, 32'h0FF);
      chk("discard_state", {28'd0, state_dbg}, 32'd0);

      // tx_start waits while the transmitter is busy
      send_byte(8'h00);
      ext_busy = 1'b1;
      rd_val   = 8'h69;
      tx0 = tx_cnt;
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h10);
      repeat (12) @(negedge clk);
      chk("busy_no_start", tx_cnt - tx0, 0);
      chk("busy_state",    {28'd0, state_dbg}, 32'd7);
      ext_busy = 1'b0;
      repeat (20) @(negedge clk);
      chk("busy_tx",  tx_cnt - tx0, 1);
      chk("busy_txd", {24'd0, tx_seen}, 32'h069);

      // Reset in the middle of a command
      send_byte(8'h02);
      send_byte(8'h12);
      rst = 1'b0;
      #1;
      chk("midrst_halt",  {31'd0, cpu_halt}, 32'd0);
      chk("midrst_state", {28'd0, state_dbg}, 32'd0);
      chk("midrst_addr",  {16'd0, bus_addr}, 32'd0);
      chk("midrst_wdata", {24'd0, bus_wdata}, 32'd0);
      chk("midrst_txd",   {24'd0, tx_data}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_byte(8'h34);
      repeat (3) @(negedge clk);
      chk("midrst_after_state", {28'd0, state_dbg}, 32'd0);

      // Partial command followed by silence
      we0 = we_cnt;
      send_byte(8'h02);
      send_byte(8'h20);
`ifdef UART_CMD_TIMEOUT_EN
      repeat (TMO + 2) @(negedge clk);
      chk("tmo_state", {28'd0, state_dbg}, 32'd0);
      send_byte(8'h00);
      repeat (2) @(negedge clk);
      chk("tmo_then_halt", {31'd0, cpu_halt}, 32'd1);
      chk("tmo_no_write",  we_cnt - we0, 0);
`else
      repeat (TMO + 20) @(negedge clk);
      chk("wait_state", {28'd0, state_dbg}, 32'd2);
      send_byte(8'h00);
      send_byte(8'h77);
      repeat (5) @(negedge clk);
      chk("wait_done_state", {28'd0, state_dbg}, 32'd0);
      chk("wait_unhalted_no_we", we_cnt - we0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
